// File: rtl/msg_stream_arbiter.sv
// Round-robin merge of AXI4-Lite response and ECD event message streams into one type-stamped stream.
// Optional MSG_ARB_STATS_EN adds per-source forwarded-message counters (rsp_count, evt_count).
`timescale 1ns/1ps

module msg_stream_arbiter #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] AXIS_RSP_TDATA,
    input  logic                  AXIS_RSP_TVALID,
    output logic                  AXIS_RSP_TREADY,
    input  logic [DATA_WIDTH-1:0] AXIS_EVT_TDATA,
    input  logic                  AXIS_EVT_TVALID,
    output logic                  AXIS_EVT_TREADY,
    output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                  AXIS_OUT_TVALID,
    input  logic                  AXIS_OUT_TREADY,
    output logic                  last_grant,
`ifdef MSG_ARB_STATS_EN
    output logic [31:0]           rsp_count,
    output logic [31:0]           evt_count,
`endif
    output logic [1:0]            dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where TVALID and TREADY are both high;
    // a source holds TDATA stable while TVALID is high, and SEND holds the output likewise.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    rsp_ready_q;
    logic                    evt_ready_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    last_grant_q;
    logic [DATA_WIDTH-1:0]   rsp_stamped;
    logic [DATA_WIDTH-1:0]   evt_stamped;

    // Top byte is replaced by the message type; everything below passes through.
    always_comb begin
        rsp_stamped = AXIS_RSP_TDATA;
        rsp_stamped[DATA_WIDTH-1 -: 8] = 8'h00;
        evt_stamped = AXIS_EVT_TDATA;
        evt_stamped[DATA_WIDTH-1 -: 8] = 8'h01;
    end

`ifdef MSG_ARB_STATS_EN
    logic [31:0] rsp_cnt_q;
    logic [31:0] evt_cnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rsp_ready_q  <= 1'b0;
            evt_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_grant_q <= 1'b1;
`ifdef MSG_ARB_STATS_EN
            rsp_cnt_q    <= '0;
            evt_cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // RSP wins when alone, or on a tie if EVT was granted last.
                    if (AXIS_RSP_TVALID && (!AXIS_EVT_TVALID || last_grant_q)) begin
                        last_grant_q <= 1'b0;
                        rsp_ready_q  <= 1'b1;
                        state_q      <= ACCEPT;
                    end else if (AXIS_EVT_TVALID) begin
                        last_grant_q <= 1'b1;
                        evt_ready_q  <= 1'b1;
                        state_q      <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    // A granted source that drops TVALID is simply waited for.
                    if (!last_grant_q && AXIS_RSP_TVALID && rsp_ready_q) begin
                        out_data_q  <= rsp_stamped;
                        rsp_ready_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end else if (last_grant_q && AXIS_EVT_TVALID && evt_ready_q) begin
                        out_data_q  <= evt_stamped;
                        evt_ready_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (out_valid_q && AXIS_OUT_TREADY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
`ifdef MSG_ARB_STATS_EN
                        if (last_grant_q) begin
                            evt_cnt_q <= evt_cnt_q + 32'd1;
                        end else begin
                            rsp_cnt_q <= rsp_cnt_q + 32'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_ready_q <= 1'b0;
                    evt_ready_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign AXIS_RSP_TREADY = rsp_ready_q;
    assign AXIS_EVT_TREADY = evt_ready_q;
    assign AXIS_OUT_TDATA  = out_data_q;
    assign AXIS_OUT_TVALID = out_valid_q;
    assign last_grant      = last_grant_q;
    assign dbg_state_o     = state_q;
`ifdef MSG_ARB_STATS_EN
    assign rsp_count       = rsp_cnt_q;
    assign evt_count       = evt_cnt_q;
`endif

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Directed bench for msg_stream_arbiter: reset, single sources, tie alternation, backpressure,
// reset during SEND and, when MSG_ARB_STATS_EN is defined, the message counters.
`timescale 1ns/1ps

module tb_msg_stream_arbiter;

    localparam int W = 256;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] rsp_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] evt_data;
    logic         evt_valid;
    logic         evt_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         last_grant;
    logic [1:0]   dbg_state;
`ifdef MSG_ARB_STATS_EN
    logic [31:0]  rsp_count;
    logic [31:0]  evt_count;
`endif

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];

    msg_stream_arbiter #(.DATA_WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .AXIS_RSP_TDATA  (rsp_data),
        .AXIS_RSP_TVALID (rsp_valid),
        .AXIS_RSP_TREADY (rsp_ready),
        .AXIS_EVT_TDATA  (evt_data),
        .AXIS_EVT_TVALID (evt_valid),
        .AXIS_EVT_TREADY (evt_ready),
        .AXIS_OUT_TDATA  (out_data),
        .AXIS_OUT_TVALID (out_valid),
        .AXIS_OUT_TREADY (out_ready),
        .last_grant      (last_grant),
`ifdef MSG_ARB_STATS_EN
        .rsp_count       (rsp_count),
        .evt_count       (evt_count),
`endif
        .dbg_state_o     (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_one(input bit is_evt, input logic [W-1:0] din,
                            output logic [W-1:0] got, output bit timed_out);
        timed_out = 1'b1;
        got       = '0;
        @(negedge clk);
        out_ready = 1'b1;
        if (is_evt) begin
            evt_data  = din;
            evt_valid = 1'b1;
        end else begin
            rsp_data  = din;
            rsp_valid = 1'b1;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got       = out_data;
                timed_out = 1'b0;
                break;
            end
        end
        rsp_valid = 1'b0;
        evt_valid = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        rsp_data  = '0;
        rsp_valid = 1'b0;
        evt_data  = '0;
        evt_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        tests_run++; if (rsp_ready !== 1'b0 || evt_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_treadys: got %b%b expected 00", rsp_ready, evt_ready); end
        tests_run++; if (last_grant !== 1'b1) begin tests_failed++; $display("FAIL reset_last_grant: got %b expected 1", last_grant); end
        tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        reset = 1'b0;
    endtask

    task automatic test_single_rsp();
        logic [W-1:0] din;
        logic [W-1:0] exp_v;
        din   = {8'hCC, 232'd0, 16'hAABB};
        exp_v = {8'h00, 232'd0, 16'hAABB};
        @(negedge clk);
        rsp_data  = din;
        rsp_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (rsp_ready !== 1'b1 || evt_ready !== 1'b0) begin tests_failed++; $display("FAIL rsp_grant_tready: got rsp=%b evt=%b expected rsp=1 evt=0", rsp_ready, evt_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rsp_early_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        tests_run++; if (rsp_ready !== 1'b0) begin tests_failed++; $display("FAIL rsp_tready_pulse: got %b expected 0", rsp_ready); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rsp_out_valid: got %b expected 1", out_valid); end
        tests_run++; if (out_data !== exp_v) begin tests_failed++; $display("FAIL rsp_out_data: got %h expected %h", out_data, exp_v); end
        rsp_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rsp_out_drop: got %b expected 0", out_valid); end
        tests_run++; if (last_grant !== 1'b0) begin tests_failed++; $display("FAIL rsp_last_grant: got %b expected 0", last_grant); end
        tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL rsp_back_idle: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_single_evt();
        logic [W-1:0] din;
        logic [W-1:0] exp_v;
        din   = {8'hEE, 240'd0, 8'h02};
        exp_v = {8'h01, 240'd0, 8'h02};
        @(negedge clk);
        evt_data  = din;
        evt_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (evt_ready !== 1'b1 || rsp_ready !== 1'b0) begin tests_failed++; $display("FAIL evt_grant_tready: got evt=%b rsp=%b expected evt=1 rsp=0", evt_ready, rsp_ready); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL evt_out_valid: got %b expected 1", out_valid); end
        tests_run++; if (out_data !== exp_v) begin tests_failed++; $display("FAIL evt_out_data: got %h expected %h", out_data, exp_v); end
        tests_run++; if (out_data[7:0] !== 8'h02) begin tests_failed++; $display("FAIL evt_code: got %h expected 02", out_data[7:0]); end
        evt_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (last_grant !== 1'b1) begin tests_failed++; $display("FAIL evt_last_grant: got %b expected 1", last_grant); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL evt_out_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_tie();
        logic [W-1:0] rsp_exp;
        logic [W-1:0] evt_exp;
        logic [W-1:0] want;
        int got_n;
        int last_cyc;
        pulse_reset();
        rsp_data  = {8'hFF, 232'd0, 16'h1111};
        evt_data  = {8'hFF, 240'd0, 8'h22};
        rsp_exp   = {8'h00, 232'd0, 16'h1111};
        evt_exp   = {8'h01, 240'd0, 8'h22};
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(rsp_exp);
            exp_q.push_back(evt_exp);
        end
        rsp_valid = 1'b1;
        evt_valid = 1'b1;
        out_ready = 1'b1;
        got_n    = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 60 && got_n < 6; cyc++) begin
            @(negedge clk);
            tests_run++; if (rsp_ready && evt_ready) begin tests_failed++; $display("FAIL tie_both_ready: cycle %0d got 11 expected at most one", cyc); end
            if (out_valid) begin
                want = exp_q.pop_front();
                tests_run++; if (out_data !== want) begin tests_failed++; $display("FAIL tie_order: msg %0d got %h expected %h", got_n, out_data, want); end
                if (got_n > 0) begin
                    tests_run++; if (cyc - last_cyc !== 3) begin tests_failed++; $display("FAIL tie_spacing: msg %0d got %0d cycles expected 3", got_n, cyc - last_cyc); end
                end
                last_cyc = cyc;
                got_n++;
            end
        end
        rsp_valid = 1'b0;
        evt_valid = 1'b0;
        tests_run++; if (got_n !== 6) begin tests_failed++; $display("FAIL tie_count: got %0d expected 6", got_n); end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] rsp_exp;
        logic [W-1:0] evt_exp;
        bit seen;
        rsp_exp = {8'h00, 232'd0, 16'h3C3C};
        evt_exp = {8'h01, 240'd0, 8'h44};
        @(negedge clk);
        out_ready = 1'b0;
        rsp_data  = {8'h5A, 232'd0, 16'h3C3C};
        rsp_valid = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL bp_first_valid: got timeout expected out_valid"); end
        rsp_valid = 1'b0;
        evt_data  = {8'h77, 240'd0, 8'h44};
        evt_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", c, out_valid); end
            tests_run++; if (out_data !== rsp_exp) begin tests_failed++; $display("FAIL bp_hold_data: cycle %0d got %h expected %h", c, out_data, rsp_exp); end
            tests_run++; if (rsp_ready !== 1'b0 || evt_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_treadys: cycle %0d got %b%b expected 00", c, rsp_ready, evt_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_delivery: got %b expected 0", out_valid); end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        tests_run++; if (!seen || out_data !== evt_exp) begin tests_failed++; $display("FAIL bp_evt_drain: got %h seen=%b expected %h", out_data, seen, evt_exp); end
        evt_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_evt_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_send();
        logic [W-1:0] got;
        logic [W-1:0] exp_v;
        bit to;
        bit seen;
        @(negedge clk);
        out_ready = 1'b0;
        rsp_data  = {8'h00, 232'd0, 16'hDEAD};
        rsp_valid = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL rst_mid_setup: got timeout expected out_valid"); end
        evt_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        tests_run++; if (rsp_ready !== 1'b0 || evt_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_treadys: got %b%b expected 00", rsp_ready, evt_ready); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL rst_mid_data: got %h expected 0", out_data); end
        tests_run++; if (last_grant !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_last_grant: got %b expected 1", last_grant); end
        rsp_valid = 1'b0;
        evt_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_v = {8'h00, 232'd0, 16'hBEEF};
        send_one(1'b0, {8'h99, 232'd0, 16'hBEEF}, got, to);
        tests_run++; if (to || got !== exp_v) begin tests_failed++; $display("FAIL rst_mid_fresh: got %h timeout=%b expected %h", got, to, exp_v); end
    endtask

`ifdef MSG_ARB_STATS_EN
    task automatic test_stats();
        logic [W-1:0] got;
        bit to;
        pulse_reset();
        tests_run++; if (rsp_count !== 32'd0 || evt_count !== 32'd0) begin tests_failed++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", rsp_count, evt_count); end
        for (int k = 0; k < 5; k++) begin
            send_one(1'b0, {8'h00, 240'd0, 8'(k)}, got, to);
            tests_run++; if (to) begin tests_failed++; $display("FAIL stats_rsp_send: msg %0d got timeout expected delivery", k); end
        end
        for (int k = 0; k < 3; k++) begin
            send_one(1'b1, {8'h00, 240'd0, 8'(k)}, got, to);
            tests_run++; if (to) begin tests_failed++; $display("FAIL stats_evt_send: msg %0d got timeout expected delivery", k); end
        end
        tests_run++; if (rsp_count !== 32'd5) begin tests_failed++; $display("FAIL stats_rsp_count: got %0d expected 5", rsp_count); end
        tests_run++; if (evt_count !== 32'd3) begin tests_failed++; $display("FAIL stats_evt_count: got %0d expected 3", evt_count); end
        force dut.evt_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.evt_cnt_q;
        send_one(1'b1, {8'h00, 240'd0, 8'h09}, got, to);
        tests_run++; if (evt_count !== 32'd0) begin tests_failed++; $display("FAIL stats_evt_wrap: got %h expected 0", evt_count); end
        tests_run++; if (rsp_count !== 32'd5) begin tests_failed++; $display("FAIL stats_rsp_hold: got %0d expected 5", rsp_count); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_rsp();
        test_single_evt();
        test_tie();
        test_backpressure();
        test_reset_mid_send();
`ifdef MSG_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1);
    end

endmodule

// File: doc/msg_stream_arbiter.md
# msg_stream_arbiter

Round-robin arbiter that merges two 256-bit message streams, AXI4-Lite transaction responses and ECD event messages, onto the single message stream consumed by the host-side event broker. It stamps each forwarded message with its message type in bits [DATA_WIDTH-1:DATA_WIDTH-8]: 0 = AXI4-Lite response, 1 = event. It guarantees neither source is starved and holds each message on the output until it is accepted.

## Interface
- DATA_WIDTH, 256, width of all TDATA buses; must be >= 16
- clk  in  1  sole clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- AXIS_RSP_TDATA  in  DATA_WIDTH  AXI4-Lite response message
- AXIS_RSP_TVALID  in  1  response message valid
- AXIS_RSP_TREADY  out  1  response message accepted (registered)
- AXIS_EVT_TDATA  in  DATA_WIDTH  event message; event code in [7:0]
- AXIS_EVT_TVALID  in  1  event message valid
- AXIS_EVT_TREADY  out  1  event message accepted (registered)
- AXIS_OUT_TDATA  out  DATA_WIDTH  merged, type-stamped message (registered)
- AXIS_OUT_TVALID  out  1  merged message valid
- AXIS_OUT_TREADY  in  1  downstream ready
- last_grant  out  1  source of the most recent grant: 0 = RSP, 1 = EVT
- rsp_count, evt_count  out  32 each  forwarded-message counters; present only with MSG_ARB_STATS_EN

## Operation
- The FSM has three states: IDLE, ACCEPT and SEND.
- **IDLE**
  - Both input TREADYs are low.
  - If exactly one TVALID is high, grant that source.
  - If both are high, grant the source that is not last_grant.
  - On a grant: update last_grant, raise the granted source's TREADY, go to ACCEPT.
  - With no TVALID, stay in IDLE.
- **ACCEPT**
  - On granted TVALID & TREADY:
    - capture TDATA into AXIS_OUT_TDATA;
    - overwrite the top byte with 8'h00 for RSP or 8'h01 for EVT;
    - drop TREADY, raise AXIS_OUT_TVALID, go to SEND.
  - If the granted TVALID drops (protocol violation), keep TREADY high and wait. Do not re-arbitrate.
- **SEND**
  - Hold AXIS_OUT_TDATA and TVALID stable.
  - On AXIS_OUT_TVALID & AXIS_OUT_TREADY: drop TVALID, go to IDLE.
- The non-granted source's TREADY is never high.
- At most one message is in flight.
- Bits [DATA_WIDTH-9:0] pass through unmodified.

## Timing
- Reset values:
  - state = IDLE
  - both input TREADYs = 0
  - AXIS_OUT_TVALID = 0
  - AXIS_OUT_TDATA = 0
  - last_grant = 1, so RSP wins the first tie
  - counters = 0
- Latency: source TVALID sampled high in IDLE at edge N → its TREADY high after edge N → capture at edge N+1 → AXIS_OUT_TVALID high after edge N+1.
- Sustained throughput with downstream always ready: one message per 3 cycles.
- Simultaneous valids: grants alternate strictly RSP/EVT/RSP/… while both stay valid.
- Downstream backpressure: SEND holds indefinitely. Inputs see TREADY low, so no data is lost.
- Reset asserted mid-operation: every register clears immediately (asynchronous). An in-flight message is discarded and no partial handshake completes.
- Reset deassertion: arbitration may begin at the first edge after release.

## Configuration
- Macro: MSG_ARB_STATS_EN
- Defined:
  - rsp_count and evt_count exist.
  - Each increments by 1 on the output handshake of a message from its source.
  - Each wraps from 32'hFFFF_FFFF to 0.
  - Both clear on reset.
- Undefined: the ports and their logic are absent. Arbitration behaviour is identical in both builds.

## Test plan
- **Single RSP:** RSP TDATA=256'h..._AABB, TVALID=1, OUT_TREADY=1.
  - RSP_TREADY pulses 1 cycle.
  - OUT_TVALID rises 2 cycles after valid, with TDATA top byte 00 and lower bits AABB.
- **Single EVT:** event code 8'h02.
  - Output top byte 01, [7:0]=02.
  - last_grant=1.
- **Tie after reset:** both valid continuously, 6 messages.
  - Output order RSP, EVT, RSP, EVT, RSP, EVT.
  - One message every 3 cycles.
- **Backpressure:** OUT_TREADY=0 for 20 cycles with a message pending.
  - OUT_TVALID and TDATA stay stable.
  - Both input TREADYs stay 0.
  - Message delivered the cycle OUT_TREADY rises.
- **Reset mid-SEND:** assert reset while OUT_TVALID=1.
  - OUT_TVALID=0 and TREADYs=0 immediately, before the next clock edge.
  - After release, a fresh RSP is forwarded normally.
- **MSG_ARB_STATS_EN:**
  - Preload traffic of 5 RSP + 3 EVT → rsp_count=5, evt_count=3.
  - Force evt_count to 32'hFFFF_FFFF, then send one EVT → evt_count=0.
